led_message_scroller: RTL and testbench

//  Controller that drives the char3..char0 inputs of the 4-digit multiplexed 7-seg display

---
 rtl/led_message_scroller.sv | 148 ++++++++++++++
 tb/tb_led_message_scroller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_message_scroller.sv
// Scrolls a 4-character window across a small message buffer of 7-seg display codes,
// stepping one position every TICK_DIV clocks and wrapping at the latched message length.
module led_message_scroller #(
    parameter int MSG_DEPTH = 16,
    parameter int ADDR_W    = 4,
    parameter int TICK_DIV  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [3:0]        wr_data_i,
    input  logic [ADDR_W:0]   msg_len_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              hold_i,
    output logic              busy_o,
    output logic              wrap_o,
    output logic [3:0]        char3_o,
    output logic [3:0]        char2_o,
    output logic [3:0]        char1_o,
    output logic [3:0]        char0_o
);

    localparam int              TICK_W     = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W:0] LEN_MAX    = (ADDR_W + 1)'(MSG_DEPTH);
    localparam logic [3:0]      CODE_BLANK = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pos_q;
    logic [TICK_W-1:0] tick_q;
    logic [ADDR_W:0]   len_q;
    logic              wrap_evt_q;
    logic              busy_q;
    logic              wrap_q;
    logic [15:0]       chars_q;
    logic [3:0]        mem_q [MSG_DEPTH];

    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   pos_inc_d;
    logic [15:0]       win_codes_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                mem_q[i] <= CODE_BLANK;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        len_d = msg_len_i;
        if (msg_len_i == '0) begin
            len_d = (ADDR_W + 1)'(1);
        end else if (msg_len_i > LEN_MAX) begin
            len_d = LEN_MAX;
        end
    end

    assign pos_inc_d = {1'b0, pos_q} + 1'b1;

    // Window offsets 0..3 reduced modulo len; with len as small as 1 the sum
    // pos+3 can exceed len three times, hence three conditional subtractions.
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
        localparam logic [ADDR_W+1:0] OFS = (ADDR_W + 2)'(gi);
        logic [ADDR_W+1:0] sum_d;

        always_comb begin
            sum_d = {2'b00, pos_q} + OFS;
            for (int r = 0; r < 3; r++) begin
                if (sum_d >= {1'b0, len_q}) begin
                    sum_d = sum_d - {1'b0, len_q};
                end
            end
        end

        assign win_codes_d[(3-gi)*4 +: 4] = mem_q[sum_d[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            tick_q     <= '0;
            len_q      <= (ADDR_W + 1)'(1);
            wrap_evt_q <= 1'b0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
            chars_q    <= {4{CODE_BLANK}};
        end else begin
            // Outputs lag the scroll state by one edge so wrap lines up with the wrapped window.
            busy_q     <= (state_q != ST_IDLE);
            wrap_q     <= wrap_evt_q;
            chars_q    <= (state_q == ST_IDLE) ? {4{CODE_BLANK}} : win_codes_d;
            wrap_evt_q <= 1'b0;

            if (stop_i) begin
                state_q <= ST_IDLE;
            end else if (start_i) begin
                state_q <= ST_RUN;
                pos_q   <= '0;
                tick_q  <= '0;
                len_q   <= len_d;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (hold_i) begin
                            state_q <= ST_HOLD;
                        end else if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            if (pos_inc_d == len_q) begin
                                pos_q      <= '0;
                                wrap_evt_q <= 1'b1;
                            end else begin
                                pos_q <= pos_inc_d[ADDR_W-1:0];
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!hold_i) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o  = busy_q;
    assign wrap_o  = wrap_q;
    assign char3_o = chars_q[15:12];
    assign char2_o = chars_q[11:8];
    assign char1_o = chars_q[7:4];
    assign char0_o = chars_q[3:0];

endmodule

// File: tb/tb_led_message_scroller.sv
// Bench for led_message_scroller: a reference model feeds a per-cycle scoreboard, while a
// vector table and short hand sequences pin the scroll/hold/wrap/length corner cases.
module tb_led_message_scroller;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [3:0] wr_addr_i = '0;
    logic [3:0] wr_data_i = '0;
    logic [4:0] msg_len_i = '0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       hold_i = 1'b0;
    logic       busy_o, wrap_o;
    logic [3:0] char3_o, char2_o, char1_o, char0_o;

    always #5 clk = ~clk;

    led_message_scroller #(
        .MSG_DEPTH(16),
        .ADDR_W   (4),
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (wr_en_i),
        .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i),
        .msg_len_i(msg_len_i),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .hold_i   (hold_i),
        .busy_o   (busy_o),
        .wrap_o   (wrap_o),
        .char3_o  (char3_o),
        .char2_o  (char2_o),
        .char1_o  (char1_o),
        .char0_o  (char0_o)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       hold;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [3:0] wr_data;
        logic [4:0] len;
        int         edges;
        logic [15:0] exp_chars;
        logic       exp_busy;
        logic       exp_wrap;
    } vec_t;

    localparam logic [17:0] RESET_OBS = {16'hCCCC, 1'b0, 1'b0};

    int n_tests = 0;
    int n_fail  = 0;
    logic [17:0] exp_q [$];
    vec_t vecs [$];

    wire [17:0] obs = {char3_o, char2_o, char1_o, char0_o, busy_o, wrap_o};

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got chars=%h busy=%b wrap=%b, expected chars=%h busy=%b wrap=%b",
                     name, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // Reference model: abstract scroll state, one expected output per clock.
    logic [3:0] m_mem [16];
    int   m_state, m_pos, m_tick, m_len;
    bit   m_wevt;
    logic [15:0] m_chars;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 4'd12;
            m_state = 0; m_pos = 0; m_tick = 0; m_len = 1; m_wevt = 0;
            exp_q.delete();
        end else begin
            for (int k = 0; k < 4; k++)
                m_chars[(3-k)*4 +: 4] = (m_state == 0) ? 4'd12 : m_mem[(m_pos + k) % m_len];
            exp_q.push_back({m_chars, m_state != 0, m_wevt});
            m_wevt = 0;
            if (wr_en_i) m_mem[wr_addr_i] = wr_data_i;
            if (stop_i) begin
                m_state = 0;
            end else if (start_i) begin
                m_state = 1; m_pos = 0; m_tick = 0;
                m_len = (msg_len_i == 0) ? 1 : (msg_len_i > 16) ? 16 : int'(msg_len_i);
            end else if (m_state == 1) begin
                if (hold_i) m_state = 2;
                else if (m_tick == TD - 1) begin
                    m_tick = 0;
                    if (m_pos + 1 == m_len) begin m_pos = 0; m_wevt = 1; end
                    else m_pos = m_pos + 1;
                end else m_tick = m_tick + 1;
            end else if (m_state == 2) begin
                if (!hold_i) m_state = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) check("sb_reset", obs, RESET_OBS);
        else if (exp_q.size() > 0) check("sb_cycle", obs, exp_q.pop_front());
    end

    function automatic vec_t mk(logic st, logic sp, logic hd, logic we, logic [3:0] wa,
                                logic [3:0] wd, logic [4:0] ln, int ed, logic [15:0] ec,
                                logic eb, logic ew);
        vec_t v;
        v.start = st; v.stop = sp; v.hold = hd; v.wr_en = we; v.wr_addr = wa;
        v.wr_data = wd; v.len = ln; v.edges = ed; v.exp_chars = ec;
        v.exp_busy = eb; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        start_i = v.start; stop_i = v.stop; hold_i = v.hold;
        wr_en_i = v.wr_en; wr_addr_i = v.wr_addr; wr_data_i = v.wr_data;
        msg_len_i = v.len;
        repeat (v.edges) begin
            @(posedge clk);
            #2;
            start_i = 1'b0; stop_i = 1'b0; wr_en_i = 1'b0;
        end
        @(negedge clk);
        check(name, obs, {v.exp_chars, v.exp_busy, v.exp_wrap});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", obs, RESET_OBS);

        for (int i = 0; i < 10; i++) begin
            wr_en_i = 1'b1; wr_addr_i = 4'(i); wr_data_i = 4'(i);
            @(posedge clk);
            #2 wr_en_i = 1'b0;
        end

        // scroll len 10 and wrap
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd10, 2,  16'h0123, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 4,  16'h1234, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 32, 16'h9012, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 4,  16'h0123, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 1,  16'h0123, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5'd10, 2,  16'hCCCC, 0, 0));
        // two-entry message
        vecs.push_back(mk(0, 0, 0, 1, 0, 5, 5'd2,  1,  16'hCCCC, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 7, 5'd2,  1,  16'hCCCC, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd2,  2,  16'h5757, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd2,  4,  16'h7575, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd2,  4,  16'h5757, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd2,  4,  16'h7575, 1, 0));
        // start+stop together, length clamps
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 5'd2,  2,  16'hCCCC, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0,  2,  16'h5555, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0,  4,  16'h5555, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd20, 2,  16'h5723, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd20, 52, 16'hCCC5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd20, 8,  16'hC572, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd20, 4,  16'h5723, 1, 1));
        // hold mid-step at tick 2
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'd10, 3,  16'h5723, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'd10, 10, 16'h5723, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 3,  16'h5723, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 1,  16'h7234, 1, 0));
        // write inside the live window
        vecs.push_back(mk(0, 0, 0, 1, 2, 11, 5'd10, 1, 16'h7234, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 1,  16'h7B34, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd10, 2,  16'hB345, 1, 0));

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // reset mid-run
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_immediate", obs, RESET_OBS);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_vec("mem_cleared", mk(1, 0, 0, 0, 0, 0, 5'd16, 2, 16'hCCCC, 1, 0));
        run_vec("stop_again",  mk(0, 1, 0, 0, 0, 0, 5'd16, 2, 16'hCCCC, 0, 0));
        run_vec("wr13",        mk(0, 0, 0, 1, 0, 13, 5'd3, 1, 16'hCCCC, 0, 0));
        run_vec("wr14",        mk(0, 0, 0, 1, 1, 14, 5'd3, 1, 16'hCCCC, 0, 0));
        run_vec("wr15",        mk(0, 0, 0, 1, 2, 15, 5'd3, 1, 16'hCCCC, 0, 0));
        run_vec("codes_13_15", mk(1, 0, 0, 0, 0, 0, 5'd3, 2, 16'hDEFD, 1, 0));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
